// File: rtl/mips_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mips_pkg: shared opcode constants, fetch FSM states and IR field layout  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package mips_pkg;

   localparam logic [5:0] OP_RTYPE   = 6'h00;
   localparam logic [5:0] FN_SYSCALL = 6'h0C;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      ISSUE = 2'd1,
      HALT  = 2'd2
   } fetch_state_t;

   localparam int OPCODE_LSB = 26;
   localparam int OPCODE_W   = 6;
   localparam int RS_LSB     = 21;
   localparam int RT_LSB     = 16;
   localparam int RD_LSB     = 11;
   localparam int REG_W      = 5;
   localparam int SHAMT_LSB  = 6;
   localparam int SHAMT_W    = 5;
   localparam int FUNC_LSB   = 0;
   localparam int FUNC_W     = 6;
   localparam int IMM_LSB    = 0;
   localparam int IMM_W      = 16;
   localparam int ADDR_LSB   = 0;
   localparam int ADDR_W     = 26;

   function automatic logic is_syscall(input logic [31:0] word);
      return (word[OPCODE_LSB +: OPCODE_W] == OP_RTYPE) &&
             (word[FUNC_LSB +: FUNC_W] == FN_SYSCALL);
   endfunction

endpackage
`default_nettype wire

// File: rtl/instruction_fetch_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | instruction_fetch_if: imem handshake, datapath handshake and IR fields   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface instruction_fetch_if;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   logic        inst_valid;
   logic        inst_accept;
   logic        pc_write;
   logic [31:0] next_pc;
   logic [31:0] previous_pc_value;

   logic [5:0]  opcode;
   logic [4:0]  rs_num;
   logic [4:0]  rt_num;
   logic [4:0]  rd_num;
   logic [4:0]  sh_mount;
   logic [5:0]  func;
   logic [15:0] imm;
   logic [25:0] address;

   logic        halted;
   logic        fetch_error;

   modport master (
      output imem_req, imem_addr,
      input  imem_ack, imem_rdata,
      output inst_valid,
      input  inst_accept, pc_write, next_pc,
      output previous_pc_value,
      output opcode, rs_num, rt_num, rd_num, sh_mount, func, imm, address,
      output halted, fetch_error
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_ack, imem_rdata,
      input  inst_valid,
      output inst_accept, pc_write, next_pc,
      input  previous_pc_value,
      input  opcode, rs_num, rt_num, rd_num, sh_mount, func, imm, address,
      input  halted, fetch_error
   );

endinterface
`default_nettype wire

// File: rtl/instruction_fetch_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_timer: counts FETCH cycles without ack; expired on the last one    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module fetch_timer #(
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  wire logic clk,
   input  wire logic rst,
   input  wire logic clear,
   input  wire logic enable,
   output logic      expired
);

   localparam int unsigned c_width = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);

   generate
      if (MEM_TIMEOUT == 0) begin : g_disabled
         logic w_unused;
         assign w_unused = clk ^ rst ^ clear ^ enable;
         assign expired  = 1'b0;
      end else begin : g_enabled
         localparam logic [c_width-1:0] c_last = c_width'(MEM_TIMEOUT - 1);
         logic [c_width-1:0] r_count;

         // expired flags the cycle that would be the MEM_TIMEOUT-th miss
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_count <= '0;
            end else if (clear) begin
               r_count <= '0;
            end else if (enable && (r_count != c_last)) begin
               r_count <= r_count + 1'b1;
            end
         end

         assign expired = (r_count == c_last);
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | instruction_fetch: PC, imem fetch, IR field split, syscall/timeout halt  |
// | Optional IFETCH_ALIGN_CHECK_EN halts on a misaligned PC.   Rev 1.0       |
// +--------------------------------------------------------------------------+
module instruction_fetch
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input wire logic            clk,
   input wire logic            rst,
   instruction_fetch_if.master bus
);

   fetch_state_t r_state;
   fetch_state_t w_state_next;

   logic [31:0] r_pc;
   logic [31:0] r_ir;
   logic [31:0] r_prev_pc;
   logic        r_fetch_error;

   logic w_misaligned;
   logic w_imem_req;
   logic w_load_ir;
   logic w_advance;
   logic w_set_error;
   logic w_timer_clear;
   logic w_timer_enable;
   logic w_timeout;

`ifdef IFETCH_ALIGN_CHECK_EN
   assign w_misaligned  = (r_pc[1:0] != 2'b00);
   assign bus.imem_addr = r_pc;
`else
   assign w_misaligned  = 1'b0;
   assign bus.imem_addr = {r_pc[31:2], 2'b00};
`endif

   assign w_timer_clear = (r_state != FETCH);

   fetch_timer #(
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (w_timer_clear),
      .enable  (w_timer_enable),
      .expired (w_timeout)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= FETCH;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next   = r_state;
      w_imem_req     = 1'b0;
      w_load_ir      = 1'b0;
      w_advance      = 1'b0;
      w_set_error    = 1'b0;
      w_timer_enable = 1'b0;
      case (r_state)
         FETCH: begin
            if (w_misaligned) begin
               w_set_error  = 1'b1;
               w_state_next = HALT;
            end else begin
               w_imem_req = 1'b1;
               if (bus.imem_ack) begin
                  w_load_ir    = 1'b1;
                  w_state_next = is_syscall(bus.imem_rdata) ? HALT : ISSUE;
               end else if (w_timeout && (MEM_TIMEOUT != 0)) begin
                  w_set_error  = 1'b1;
                  w_state_next = HALT;
               end else begin
                  w_timer_enable = 1'b1;
               end
            end
         end
         ISSUE: begin
            if (bus.inst_accept) begin
               w_advance    = 1'b1;
               w_state_next = FETCH;
            end
         end
         HALT: begin
            w_state_next = HALT;
         end
         default: begin
            w_state_next = HALT;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc          <= RESET_PC;
         r_prev_pc     <= RESET_PC;
         r_ir          <= '0;
         r_fetch_error <= 1'b0;
      end else begin
         if (w_load_ir) begin
            r_ir      <= bus.imem_rdata;
            r_prev_pc <= r_pc;
         end
         if (w_advance) begin
            r_pc <= bus.pc_write ? bus.next_pc : (r_pc + 32'd4);
         end
         if (w_set_error) begin
            r_fetch_error <= 1'b1;
         end
      end
   end

   // State resets to FETCH asynchronously, so the request is masked while rst is high
   assign bus.imem_req          = w_imem_req & ~rst;
   assign bus.inst_valid        = (r_state == ISSUE);
   assign bus.halted            = (r_state == HALT);
   assign bus.fetch_error       = r_fetch_error;
   assign bus.previous_pc_value = r_prev_pc;

   assign bus.opcode   = r_ir[OPCODE_LSB +: OPCODE_W];
   assign bus.rs_num   = r_ir[RS_LSB     +: REG_W];
   assign bus.rt_num   = r_ir[RT_LSB     +: REG_W];
   assign bus.rd_num   = r_ir[RD_LSB     +: REG_W];
   assign bus.sh_mount = r_ir[SHAMT_LSB  +: SHAMT_W];
   assign bus.func     = r_ir[FUNC_LSB   +: FUNC_W];
   assign bus.imm      = r_ir[IMM_LSB    +: IMM_W];
   assign bus.address  = r_ir[ADDR_LSB   +: ADDR_W];

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_instruction_fetch: directed + random fetch traffic, scoreboard check  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_instruction_fetch;

   localparam logic [31:0] RPC      = 32'h0000_0100;
   localparam logic [31:0] ADD_WORD = 32'h012A_4020;

   logic clk;
   logic rst;

   instruction_fetch_if bus ();

   instruction_fetch #(
      .RESET_PC    (RPC),
      .MEM_TIMEOUT (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] word;
   } exp_t;

   exp_t        exp_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] model_pc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic checkb(input string name, input logic act, input logic exp);
      check(name, {31'd0, act}, {31'd0, exp});
   endtask

   function automatic logic word_is_syscall(input logic [31:0] w);
      return ((w >> 26) == 32'd0) && ((w & 32'h3F) == 32'h0C);
   endfunction

   function automatic logic [31:0] rand_word();
      logic [31:0] w;
      w = $urandom;
      if (word_is_syscall(w)) w = w ^ 32'h1;
      return w;
   endfunction

   // Monitor: pops the expected instruction whenever a new one is presented
   initial begin : monitor
      logic prev_valid;
      exp_t e;
      prev_valid = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_valid = 1'b0;
         end else begin
            if (bus.inst_valid) checkb("valid_with_halted", bus.halted, 1'b0);
            if (bus.inst_valid && !prev_valid) begin
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL sb_unexpected: got instruction pc %h required none",
                           bus.previous_pc_value);
               end else begin
                  e = exp_q.pop_front();
                  check("sb_prev_pc", bus.previous_pc_value, e.pc);
                  check("sb_opcode",  32'(bus.opcode),   e.word >> 26);
                  check("sb_rs",      32'(bus.rs_num),   (e.word >> 21) & 32'h1F);
                  check("sb_rt",      32'(bus.rt_num),   (e.word >> 16) & 32'h1F);
                  check("sb_rd",      32'(bus.rd_num),   (e.word >> 11) & 32'h1F);
                  check("sb_shamt",   32'(bus.sh_mount), (e.word >> 6) & 32'h1F);
                  check("sb_func",    32'(bus.func),     e.word & 32'h3F);
                  check("sb_imm",     32'(bus.imm),      e.word & 32'hFFFF);
                  check("sb_address", 32'(bus.address),  e.word & 32'h03FF_FFFF);
               end
            end
            prev_valid = bus.inst_valid;
         end
      end
   end

   task automatic do_reset();
      rst              = 1'b1;
      bus.imem_ack     = 1'b0;
      bus.imem_rdata   = 32'd0;
      bus.inst_accept  = 1'b0;
      bus.pc_write     = 1'b0;
      bus.next_pc      = 32'd0;
      repeat (2) @(negedge clk);
      checkb("rst_req",      bus.imem_req,    1'b0);
      checkb("rst_valid",    bus.inst_valid,  1'b0);
      checkb("rst_halted",   bus.halted,      1'b0);
      checkb("rst_err",      bus.fetch_error, 1'b0);
      check ("rst_prev_pc",  bus.previous_pc_value, RPC);
      check ("rst_opcode",   32'(bus.opcode),  32'd0);
      check ("rst_address",  32'(bus.address), 32'd0);
      exp_q.delete();
      model_pc = RPC;
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // One FETCH: ack after `delay` wait cycles
   task automatic fetch_one(input logic [31:0] word, input int delay);
      for (int i = 0; i <= delay; i++) begin
         @(negedge clk);
         bus.inst_accept = 1'b0;
         bus.pc_write    = 1'b0;
         checkb("fetch_req",   bus.imem_req,   1'b1);
         check ("fetch_addr",  bus.imem_addr,  model_pc & ~32'h3);
         checkb("fetch_valid", bus.inst_valid, 1'b0);
         if (i == delay) begin
            bus.imem_ack   = 1'b1;
            bus.imem_rdata = word;
            if (!word_is_syscall(word)) exp_q.push_back('{pc: model_pc, word: word});
         end else begin
            bus.imem_ack   = 1'b0;
            bus.imem_rdata = $urandom;
         end
      end
   endtask

   // Hold in ISSUE for `hold` cycles with ignored noise, then accept
   task automatic accept_instr(input int hold, input logic pw, input logic [31:0] npc);
      for (int i = 0; i <= hold; i++) begin
         @(negedge clk);
         checkb("issue_valid", bus.inst_valid, 1'b1);
         checkb("issue_req",   bus.imem_req,   1'b0);
         bus.imem_ack   = 1'($urandom_range(0, 1));
         bus.imem_rdata = $urandom;
         if (i == hold) begin
            bus.inst_accept = 1'b1;
            bus.pc_write    = pw;
            bus.next_pc     = npc;
            model_pc        = pw ? npc : model_pc + 32'd4;
         end else begin
            bus.inst_accept = 1'b0;
            bus.pc_write    = 1'($urandom_range(0, 1));
            bus.next_pc     = $urandom;
         end
      end
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got no finish required finish before time limit");
      $fatal(1);
   end

   initial begin : main
      do_reset();

      // Zero-wait memory, accept on first ISSUE cycle: one instruction per 2 cycles
      for (int i = 0; i < 3; i++) begin
         fetch_one(ADD_WORD, 0);
         accept_instr(0, 1'b0, 32'd0);
         check("add_rs",   32'(bus.rs_num), 32'd9);
         check("add_rt",   32'(bus.rt_num), 32'd10);
         check("add_rd",   32'(bus.rd_num), 32'd8);
         check("add_func", 32'(bus.func),   32'h20);
      end

      fetch_one(rand_word(), 3);
      accept_instr(0, 1'b1, 32'h0000_0200);
      fetch_one(rand_word(), 0);
      accept_instr(1, 1'b0, 32'h0);
      fetch_one(rand_word(), 1);
      accept_instr(0, 1'b1, 32'hFFFF_FFFC);
      fetch_one(rand_word(), 2);
      accept_instr(0, 1'b0, 32'h0);
      fetch_one(rand_word(), 0);
      check("wrap_prev_pc", bus.previous_pc_value, 32'hFFFF_FFFC);
      accept_instr(0, 1'b1, 32'h0000_0202);
`ifdef IFETCH_ALIGN_CHECK_EN
      @(negedge clk);
      checkb("align_no_req",   bus.imem_req, 1'b0);
      checkb("align_not_yet",  bus.halted,   1'b0);
      @(negedge clk);
      checkb("align_halted",   bus.halted,      1'b1);
      checkb("align_err",      bus.fetch_error, 1'b1);
      checkb("align_req_off",  bus.imem_req,    1'b0);
`else
      fetch_one(rand_word(), 1);
      accept_instr(0, 1'b0, 32'h0);
      fetch_one(rand_word(), 0);
      accept_instr(0, 1'b0, 32'h0);
      checkb("align_no_err", bus.fetch_error, 1'b0);
`endif

      // Timeout: ack held low
      do_reset();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus.imem_ack = 1'b0;
         checkb("to_req",        bus.imem_req, 1'b1);
         checkb("to_not_halted", bus.halted,   1'b0);
      end
      @(negedge clk);
      checkb("to_halted", bus.halted,      1'b1);
      checkb("to_err",    bus.fetch_error, 1'b1);
      checkb("to_req",    bus.imem_req,    1'b0);
      checkb("to_valid",  bus.inst_valid,  1'b0);

      // Syscall halts cleanly without an error
      do_reset();
      fetch_one(rand_word(), 0);
      accept_instr(0, 1'b0, 32'h0);
      fetch_one(32'h0000_000C, 1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus.imem_ack    = 1'($urandom_range(0, 1));
         bus.inst_accept = 1'($urandom_range(0, 1));
         checkb("sys_halted", bus.halted,      1'b1);
         checkb("sys_valid",  bus.inst_valid,  1'b0);
         checkb("sys_req",    bus.imem_req,    1'b0);
         checkb("sys_err",    bus.fetch_error, 1'b0);
      end

      // Reset restarts at RESET_PC, then random traffic
      do_reset();
      for (int k = 0; k < 150; k++) begin
         fetch_one(rand_word(), $urandom_range(0, 3));
         accept_instr($urandom_range(0, 2), 1'($urandom_range(0, 1)), $urandom & ~32'h3);
      end
      @(negedge clk);
      bus.inst_accept = 1'b0;
      bus.imem_ack    = 1'b0;
      #1;
      check("sb_drained", exp_q.size(), 32'd0);
      checkb("rand_no_err", bus.fetch_error, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/instruction_fetch.md
# instruction_fetch

Front-end stage of the single-cycle MIPS core. It holds the PC, fetches one instruction word per step over a req/ack instruction-memory handshake, and latches it in an instruction register. It splits the word into the field buses consumed by the datapath (opcode, rs/rt/rd numbers, shift amount, func, imm, jump address) and takes the datapath's next-PC back to advance. It also detects `syscall` and memory timeouts and drives the core-wide `halted` signal.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset
- `MEM_TIMEOUT`, 255, maximum FETCH wait cycles without `imem_ack`; 0 disables the timeout
- `clk`  in  1  core clock; all state updates on the rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `imem_req`  out  1  instruction read request
- `imem_addr`  out  32  word address of the request (current PC)
- `imem_ack`  in  1  read data valid this cycle
- `imem_rdata`  in  32  instruction word
- `inst_valid`  out  1  field outputs hold an instruction for the datapath
- `inst_accept`  in  1  datapath has completed the presented instruction
- `pc_write`  in  1  datapath redirects the PC (jump/branch taken)
- `next_pc`  in  32  redirect target, used when `pc_write` is high
- `previous_pc_value`  out  32  PC of the instruction in the IR
- `opcode` 6, `rs_num` 5, `rt_num` 5, `rd_num` 5, `sh_mount` 5, `func` 6, `imm` 16, `address` 26  out  IR fields [31:26], [25:21], [20:16], [15:11], [10:6], [5:0], [15:0], [25:0]
- `halted`  out  1  core stopped; sticky until reset
- `fetch_error`  out  1  timeout or misalignment caused the halt; sticky

## Operation
- States: FETCH, ISSUE, HALT. Reset state is FETCH.
- FETCH
  - `imem_req`=1, `imem_addr`=PC.
  - On `imem_ack`: load the IR from `imem_rdata` and set `previous_pc_value`=PC.
  - If the word is `syscall` (opcode 0, func 6'h0C), go to HALT. Otherwise go to ISSUE.
- ISSUE
  - `inst_valid`=1 and the fields are stable.
  - On `inst_accept`: PC ← `pc_write` ? `next_pc` : PC+4 (modulo 2^32; wraps 32'hFFFF_FFFC→0), then go to FETCH.
- HALT
  - `halted`=1, `imem_req`=0, `inst_valid`=0.
  - Only reset leaves this state.
- Timeout
  - A counter clears on entry to FETCH and increments each FETCH cycle without ack.
  - When it reaches `MEM_TIMEOUT` (nonzero) with no ack in that cycle, set `fetch_error`=1 and go to HALT.
- Inputs ignored outside their state: `imem_ack` outside FETCH; `inst_accept` and `pc_write` outside ISSUE; `pc_write` without `inst_accept`.
- Reset mid-operation aborts any pending request. Memory tolerates a dropped req.

## Timing
- Reset values:
  - PC and `previous_pc_value` = `RESET_PC`.
  - IR = 0 (all fields 0).
  - `imem_req`, `inst_valid`, `halted`, `fetch_error` = 0 while `rst` is high.
- `imem_req`=1 in the first cycle after reset deasserts.
- Ack in cycle N → `inst_valid`=1 in cycle N+1.
- Zero-wait memory (ack in the same cycle as req) gives one instruction per 2 cycles when `inst_accept` is tied high.
- Accept in cycle M → `imem_req`=1 with the new PC in cycle M+1.
- `halted` rises the cycle after the ack of a syscall, or after the timeout cycle.
- `inst_valid` is never high together with `halted`.

## Configuration
- `IFETCH_ALIGN_CHECK_EN` defined:
  - On entering FETCH with PC[1:0]≠0, no request is issued.
  - `fetch_error`=1 and `halted`=1 in the next cycle.
- Not defined: `imem_addr` = {PC[31:2],2'b00}, and the low bits are ignored silently.

## Structure
- Shared package `mips_pkg` holds:
  - `OP_RTYPE`=6'h00 and `FN_SYSCALL`=6'h0C.
  - The `fetch_state_t` enum {FETCH, ISSUE, HALT}.
  - The instruction field slice positions.
- One sub-module, `fetch_timer`: timeout counter with clear, enable, and an `expired` flag; width derived from `MEM_TIMEOUT`.

## Test plan
- Reset with `RESET_PC`=0x100, zero-wait memory returning ADD (0x012A4020), `inst_accept`=1 → fetch addresses 0x100, 0x104, 0x108; `rs_num`=9, `rt_num`=10, `rd_num`=8, `func`=0x20.
- Ack delayed 3 cycles → `inst_valid` stays 0 until the cycle after ack; `previous_pc_value` matches the fetched address.
- Accept with `pc_write`=1, `next_pc`=0x200 → next `imem_addr`=0x200; with `pc_write`=0 → PC+4. PC=0xFFFF_FFFC accepted without redirect → next fetch address is 0.
- Word 0x0000000C fetched → `halted`=1 next cycle, `inst_valid`=0, no further `imem_req`; reset restarts at `RESET_PC`.
- `MEM_TIMEOUT`=4 with `imem_ack` held low → `fetch_error`=`halted`=1 after 4 FETCH cycles.
- With `IFETCH_ALIGN_CHECK_EN`, redirect to 0x202 → no request, `fetch_error`=1. Without the macro → `imem_addr`=0x200.
